eq_i2s_rx: RTL and testbench

I2S receiver front end for the equalizer chain. It oversamples the external I2S bus (bclk, lrclk, sdata) in the system `clk` domain and deserializes the MSB-first word of the selected channel. It presents each captured word as a signed `SAMPLE_BITS` sample with a one-cycle `sample_valid` strobe. The sample is held stable between strobes, so it can drive the equalizer's `filter_in` directly, with `sample_valid` marking the start of each new filtering period.

---
 rtl/eq_i2s_rx.sv | 198 +++++++++++++++++++
 tb/tb_eq_i2s_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/eq_i2s_rx.sv
// I2S receiver front end: oversamples bclk/lrclk/sdata in the clk domain and deserializes one channel.
// Define EQ_I2S_RX_MONO_MIX_EN to capture both channels and output the (L+R)>>>1 mono mix instead.
module eq_i2s_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int CHANNEL_SEL = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i2s_bclk,
    input  logic                          i2s_lrclk,
    input  logic                          i2s_sdata,
    output logic signed [SAMPLE_BITS-1:0] sample_out,
    output logic                          sample_valid,
    output logic                          frame_error
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SKIP} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_prev;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SAMPLE_BITS-2:0] shreg;
    logic                   lr_prev;
    logic                   lr_primed;

    logic                   bclk_s;
    logic                   lr_s;
    logic                   sd_s;
    logic                   bclk_rise;
    logic                   lr_edge;
    logic [SAMPLE_BITS-1:0] word_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign sd_s      = sd_sync[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    // The first sample after reset only primes lr_prev, so a mid-frame release never looks like a channel start.
    assign lr_edge   = lr_primed & (lr_s != lr_prev);
    assign word_next = {shreg, sd_s};

`ifdef EQ_I2S_RX_MONO_MIX_EN
    logic [SAMPLE_BITS-1:0] left_hold;
    logic                   left_ok;
    logic                   right_ch;
    logic signed [SAMPLE_BITS:0] mix_sum;

    assign mix_sum = $signed({left_hold[SAMPLE_BITS-1], left_hold})
                   + $signed({word_next[SAMPLE_BITS-1], word_next});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            lr_prev      <= 1'b0;
            lr_primed    <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            left_hold    <= '0;
            left_ok      <= 1'b0;
            right_ch     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (bclk_rise) begin
                lr_prev   <= lr_s;
                lr_primed <= 1'b1;
                case (state)
                    IDLE: begin
                        if (lr_edge) begin
                            cnt      <= '0;
                            right_ch <= 1'b0;
                            left_ok  <= 1'b0;
                            state    <= lr_s ? SKIP : SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (lr_edge) begin
                            frame_error <= 1'b1;
                            cnt         <= '0;
                            right_ch    <= 1'b0;
                            left_ok     <= 1'b0;
                            state       <= lr_s ? SKIP : SHIFT;
                        end else begin
                            shreg <= word_next[SAMPLE_BITS-2:0];
                            cnt   <= cnt + CW'(1);
                            if (cnt == LAST_BIT) begin
                                if (!right_ch) begin
                                    left_hold <= word_next;
                                    left_ok   <= 1'b1;
                                end else begin
                                    if (left_ok) begin
                                        sample_out   <= SAMPLE_BITS'(mix_sum >>> 1);
                                        sample_valid <= 1'b1;
                                    end
                                    left_ok <= 1'b0;
                                end
                                state <= SKIP;
                            end
                        end
                    end
                    SKIP: begin
                        // A right slot is only worth capturing when this frame's left word arrived intact.
                        if (lr_edge && !lr_s) begin
                            cnt      <= '0;
                            right_ch <= 1'b0;
                            left_ok  <= 1'b0;
                            state    <= SHIFT;
                        end else if (lr_edge && left_ok) begin
                            cnt      <= '0;
                            right_ch <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    localparam logic SEL_LVL = (CHANNEL_SEL != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            lr_prev      <= 1'b0;
            lr_primed    <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (bclk_rise) begin
                lr_prev   <= lr_s;
                lr_primed <= 1'b1;
                case (state)
                    IDLE: begin
                        if (lr_edge) begin
                            cnt   <= '0;
                            state <= (lr_s == SEL_LVL) ? SHIFT : SKIP;
                        end
                    end
                    SHIFT: begin
                        // The bit sampled with the lrclk change is the previous word's LSB, never shifted in.
                        if (lr_edge) begin
                            frame_error <= 1'b1;
                            cnt         <= '0;
                            state       <= (lr_s == SEL_LVL) ? SHIFT : SKIP;
                        end else begin
                            shreg <= word_next[SAMPLE_BITS-2:0];
                            cnt   <= cnt + CW'(1);
                            if (cnt == LAST_BIT) begin
                                sample_out   <= word_next;
                                sample_valid <= 1'b1;
                                state        <= SKIP;
                            end
                        end
                    end
                    SKIP: begin
                        if (lr_edge && (lr_s == SEL_LVL)) begin
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_eq_i2s_rx.sv
// Directed bench for eq_i2s_rx: drives an I2S bus at clk/8 into a left- and a right-channel instance.
module tb_eq_i2s_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] sample0;
    logic [15:0] sample1;
    logic        valid0;
    logic        valid1;
    logic        err0;
    logic        err1;

    int  assertCount = 0;
    int  failCount   = 0;
    int  validCnt0   = 0;
    int  validCnt1   = 0;
    int  errCnt0     = 0;
    int  errCnt1     = 0;
    int  overlapCnt  = 0;
    int  savedValid  = 0;
    time lastValid1  = 0;
    time lastRise16  = 0;
    logic carry      = 1'b0;

    always #5 clk = ~clk;

    eq_i2s_rx #(.SAMPLE_BITS(16), .CHANNEL_SEL(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .sample_out(sample0), .sample_valid(valid0), .frame_error(err0)
    );

    eq_i2s_rx #(.SAMPLE_BITS(16), .CHANNEL_SEL(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .sample_out(sample1), .sample_valid(valid1), .frame_error(err1)
    );

    // Pulse counters sampled on the inactive edge
    always @(negedge clk) begin
        if (valid0) validCnt0++;
        if (valid1) begin
            validCnt1++;
            lastValid1 = $time;
        end
        if (err0) errCnt0++;
        if (err1) errCnt1++;
        if ((valid0 && err0) || (valid1 && err1)) overlapCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One slot of nbits bclk periods; data is MSB-aligned and delayed one bit behind lrclk
    task automatic applyStimulus(input logic lr, input logic [31:0] data, input int nbits);
        int idx;
        for (int i = 0; i < nbits; i++) begin
            bclk  = 1'b0;
            lrclk = lr;
            if (i == 0) begin
                sdata = carry;
            end else begin
                idx   = 32 - i;
                sdata = data[idx];
            end
            #40;
            bclk = 1'b1;
            if (i == 16) lastRise16 = $time;
            #40;
        end
        if (nbits > 0) begin
            idx   = 32 - nbits;
            carry = data[idx];
        end
    endtask

    task automatic applyFrame(input logic [31:0] left, input logic [31:0] right, input int lbits, input int rbits);
        applyStimulus(1'b0, left, lbits);
        applyStimulus(1'b1, right, rbits);
    endtask

    initial begin
        rst   = 1'b1;
        bclk  = 1'b0;
        lrclk = 1'b1;
        sdata = 1'b0;
        #12;
        checkOutput("reset sample_out", 32'(sample0), 32'h0);
        checkOutput("reset sample_valid", 32'(valid0), 32'h0);
        checkOutput("reset frame_error", 32'(err0), 32'h0);
        #20;
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0, 32);

`ifndef EQ_I2S_RX_MONO_MIX_EN
        repeat (4) applyFrame(32'h1234_0000, 32'hABCD_0000, 32, 32);
        #200;
        checkOutput("left sample", 32'(sample0), 32'h1234);
        checkOutput("left strobe count", 32'(validCnt0), 32'd4);
        checkOutput("right sample", 32'(sample1), 32'hABCD);
        checkOutput("right strobe count", 32'(validCnt1), 32'd4);
        checkOutput("right strobe latency", 32'(lastValid1 - lastRise16), 32'd28);
        checkOutput("no error clean", 32'(errCnt0 + errCnt1), 32'd0);

        applyFrame(32'h8001_FF00, 32'h0, 32, 32);
        #200;
        checkOutput("24-bit word", 32'(sample0), 32'h8001);
        checkOutput("24-bit strobe count", 32'(validCnt0), 32'd5);
        checkOutput("right zero word", 32'(sample1), 32'h0);

        applyFrame(32'h1111_0000, 32'h2222_0000, 32, 32);
        #200;
        checkOutput("trunc frame1", 32'(sample0), 32'h1111);
        savedValid = validCnt0;
        applyFrame(32'h3333_0000, 32'h4444_0000, 10, 32);
        #200;
        checkOutput("trunc error pulse", 32'(errCnt0), 32'd1);
        checkOutput("trunc no strobe", 32'(validCnt0), 32'(savedValid));
        checkOutput("trunc sample held", 32'(sample0), 32'h1111);
        checkOutput("trunc right ok", 32'(sample1), 32'h4444);
        applyFrame(32'h5555_0000, 32'h6666_0000, 32, 32);
        #200;
        checkOutput("trunc recovery", 32'(sample0), 32'h5555);
        checkOutput("trunc recovery strobe", 32'(validCnt0), 32'(savedValid + 1));

        applyFrame(32'hA5A5_0000, 32'h0, 17, 32);
        #200;
        checkOutput("17-bit slot", 32'(sample0), 32'hA5A5);
        applyFrame(32'h5A5A_0000, 32'h0, 16, 32);
        #200;
        checkOutput("16-bit slot error", 32'(errCnt0), 32'd2);
        checkOutput("16-bit slot held", 32'(sample0), 32'hA5A5);

        applyStimulus(1'b0, 32'h7777_0000, 8);
        rst = 1'b1;
        #1;
        checkOutput("midword reset sample0", 32'(sample0), 32'h0);
        checkOutput("midword reset sample1", 32'(sample1), 32'h0);
        checkOutput("midword reset flags", 32'({valid0, err0, valid1, err1}), 32'h0);
        #19;
        rst = 1'b0;
        savedValid = validCnt0;
        applyStimulus(1'b0, 32'h7777_0000, 24);
        applyStimulus(1'b1, 32'h2468_0000, 32);
        #200;
        checkOutput("partial frame no strobe", 32'(validCnt0), 32'(savedValid));
        checkOutput("partial frame sample", 32'(sample0), 32'h0);
        checkOutput("post reset right", 32'(sample1), 32'h2468);
        applyFrame(32'h1357_0000, 32'h0, 32, 32);
        #200;
        checkOutput("post reset left", 32'(sample0), 32'h1357);
        checkOutput("post reset strobe", 32'(validCnt0), 32'(savedValid + 1));
        checkOutput("right never errors", 32'(errCnt1), 32'd0);
`else
        applyFrame(32'h7FFF_0000, 32'h7FFF_0000, 32, 32);
        #200;
        checkOutput("mix max", 32'(sample0), 32'h7FFF);
        checkOutput("mix max strobe", 32'(validCnt0), 32'd1);
        applyFrame(32'h8000_0000, 32'h0001_0000, 32, 32);
        #200;
        checkOutput("mix neg", 32'(sample0), 32'hC000);
        checkOutput("mix neg strobe", 32'(validCnt0), 32'd2);
        applyFrame(32'h1000_0000, 32'h2000_0000, 32, 10);
        applyFrame(32'h4000_0000, 32'h2000_0000, 32, 32);
        #200;
        checkOutput("mix trunc error", 32'(errCnt0), 32'd1);
        checkOutput("mix trunc strobes", 32'(validCnt0), 32'd3);
        checkOutput("mix recovery", 32'(sample0), 32'h3000);
        checkOutput("mix ignores sel", 32'(sample1), 32'h3000);
`endif
        checkOutput("pulse overlap", 32'(overlapCnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
